// File: rtl/wb_xbar_pkg.sv
// -----------------------------------------------------------------------------
// wb_xbar_pkg
// Shared types and constants for the single-master Wishbone crossbar.
//   state_e       : crossbar FSM state (IDLE / ACTIVE / RESP)
//   ERR_PATTERN   : read data returned to the master on an error response
//   MAX_SLAVES    : upper bound on slave ports supported by the decoder
//   slave_onehot  : slave index -> one-hot select vector (MAX_SLAVES wide)
// -----------------------------------------------------------------------------
package wb_xbar_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic [31:0] ERR_PATTERN = 32'hDEAD_BEEF;
  localparam int          MAX_SLAVES  = 16;

  // One-hot of a 4-bit slave index; callers truncate to their slave count.
  function automatic logic [MAX_SLAVES-1:0] slave_onehot(input logic [3:0] idx);
    logic [MAX_SLAVES-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage : wb_xbar_pkg

// File: rtl/wb_timeout_cnt.sv
// -----------------------------------------------------------------------------
// wb_timeout_cnt
// Watchdog for a slave access. Counts enabled cycles since the last clear and
// flags the cycle in which the TIMEOUT-th enabled cycle is being spent.
//   clk_i      in  clock
//   rst_i      in  synchronous active-high reset
//   clr_i      in  clear count to zero (wins over enable)
//   en_i       in  count this cycle
//   expired_o  out high while enabled and count == TIMEOUT-1
// -----------------------------------------------------------------------------
module wb_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Saturating count: parks at TIMEOUT rather than wrapping back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_W'(TIMEOUT))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule : wb_timeout_cnt

// File: rtl/wb_xbar_1ton.sv
// -----------------------------------------------------------------------------
// wb_xbar_1ton
// Single-master, N-slave Wishbone classic interconnect. The master address
// field [SEL_LSB +: SEL_W] picks a slave; the cycle is forwarded to it and the
// response is registered back to the master. Unmapped accesses and slaves that
// never ack are turned into an error response (ERR_PATTERN, err_o=1) so the
// master always sees exactly one ack per access.
//
// Handshake: an access is requested while m_cyc_i & m_stb_i are high; the
// crossbar answers with a single-cycle m_ack_o (with err_o for errors). The
// master holds its request until it samples ack and drops it one cycle later.
// Slave side: s_cyc_o/s_stb_o stay high on the selected slave until it returns
// s_ack_i; acks from other slaves or outside an active forward are ignored.
// Dropping m_cyc_i mid-access aborts it without an ack.
//
// Ports
//   wb_clk_i, soc_rst_i          clock, synchronous active-high reset
//   m_addr_i/m_wdata_i/m_we_i/
//   m_sel_i/m_cyc_i/m_stb_i      master request
//   m_rdata_o, m_ack_o           registered response to master
//   s_addr_o/s_wdata_o/s_sel_o   broadcast to all slaves
//   s_we_o                       write enable, only while forwarding
//   s_cyc_o, s_stb_o             one-hot per-slave cycle/strobe
//   s_rdata_i, s_ack_i           per-slave response (slave k at k*DATA_W)
//   err_o                        error qualifier for m_ack_o
//   err_addr_o                   address of the most recent errored access
// -----------------------------------------------------------------------------
module wb_xbar_1ton
  import wb_xbar_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int N_SLAVES = 4,
  parameter int SEL_LSB  = 16,
  parameter int SEL_W    = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic                       wb_clk_i,
  input  logic                       soc_rst_i,
  input  logic [ADDR_W-1:0]          m_addr_i,
  input  logic [DATA_W-1:0]          m_wdata_i,
  input  logic                       m_we_i,
  input  logic [DATA_W/8-1:0]        m_sel_i,
  input  logic                       m_cyc_i,
  input  logic                       m_stb_i,
  output logic [DATA_W-1:0]          m_rdata_o,
  output logic                       m_ack_o,
  output logic [ADDR_W-1:0]          s_addr_o,
  output logic [DATA_W-1:0]          s_wdata_o,
  output logic                       s_we_o,
  output logic [DATA_W/8-1:0]        s_sel_o,
  output logic [N_SLAVES-1:0]        s_cyc_o,
  output logic [N_SLAVES-1:0]        s_stb_o,
  input  logic [N_SLAVES*DATA_W-1:0] s_rdata_i,
  input  logic [N_SLAVES-1:0]        s_ack_i,
  output logic                       err_o,
  output logic [ADDR_W-1:0]          err_addr_o
);

  localparam logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_PATTERN);

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic [SEL_W-1:0] idx;
  logic             mapped;
  logic             req;

  assign idx    = m_addr_i[SEL_LSB +: SEL_W];
  assign mapped = (32'(idx) < 32'(N_SLAVES));
  assign req    = m_cyc_i & m_stb_i;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_e              state_q, state_d;
  logic [3:0]          sel_q, sel_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   err_addr_q, err_addr_d;

  // ---------------------------------------------------------------------------
  // Selected-slave response mux (one-hot AND-OR, no wide index)
  // ---------------------------------------------------------------------------
  logic [N_SLAVES-1:0] sel_oh;
  logic                ack_sel;
  logic [DATA_W-1:0]   rdata_sel;

  assign sel_oh  = N_SLAVES'(slave_onehot(sel_q));
  assign ack_sel = |(s_ack_i & sel_oh);

  always_comb begin
    rdata_sel = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (sel_oh[k]) begin
        rdata_sel = rdata_sel | s_rdata_i[k*DATA_W +: DATA_W];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Timeout watchdog: cleared whenever no slave is being forwarded to, so it
  // always starts from zero on entry to ACTIVE.
  // ---------------------------------------------------------------------------
  logic tmo_expired;

  wb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk_i     (wb_clk_i),
    .rst_i     (soc_rst_i),
    .clr_i     (state_q != ST_ACTIVE),
    .en_i      (state_q == ST_ACTIVE),
    .expired_o (tmo_expired)
  );

  // ---------------------------------------------------------------------------
  // FSM process 1: state / datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i) begin
    if (soc_rst_i) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 2: next state and datapath updates
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (mapped) begin
            sel_d   = 4'(idx);
            state_d = ST_ACTIVE;
          end else begin
            rdata_d    = ERR_DATA;
            err_addr_d = m_addr_i;
            err_d      = 1'b1;
            state_d    = ST_RESP;
          end
        end
      end

      ST_ACTIVE: begin
        // Abort first: with cyc low the slave strobe is already gone, so any
        // ack seen now does not belong to a live request.
        if (!m_cyc_i) begin
          state_d = ST_IDLE;
        end else if (ack_sel) begin
          // A real ack beats a simultaneous watchdog expiry.
          rdata_d = rdata_sel;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (tmo_expired) begin
          rdata_d    = ERR_DATA;
          err_addr_d = m_addr_i;
          err_d      = 1'b1;
          state_d    = ST_RESP;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM process 3: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    s_cyc_o = '0;
    s_stb_o = '0;
    s_we_o  = 1'b0;
    m_ack_o = 1'b0;
    err_o   = 1'b0;

    case (state_q)
      ST_ACTIVE: begin
        if (req) begin
          s_cyc_o = sel_oh;
          s_stb_o = sel_oh;
        end
        s_we_o = m_we_i;
      end
      ST_RESP: begin
        m_ack_o = 1'b1;
        err_o   = err_q;
      end
      default: begin
      end
    endcase
  end

  assign m_rdata_o  = rdata_q;
  assign err_addr_o = err_addr_q;
  assign s_addr_o   = m_addr_i;
  assign s_wdata_o  = m_wdata_i;
  assign s_sel_o    = m_sel_i;

endmodule : wb_xbar_1ton

// File: tb/tb_wb_xbar_1ton.sv
// -----------------------------------------------------------------------------
// tb_wb_xbar_1ton
// Bench for wb_xbar_1ton (N_SLAVES=4, TIMEOUT=8). The driver walks each access
// cycle by cycle from a timeline computed out of the access parameters (slave
// ack delay, abort/reset point) and publishes the expected outputs for that
// cycle; a negedge monitor compares every output against those expectations.
// -----------------------------------------------------------------------------
module tb_wb_xbar_1ton;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NS = 4;
  localparam int SL = 16;
  localparam int SW = 4;
  localparam int TO = 8;

  // ---------------- clock / reset ----------------
  logic wb_clk_i = 1'b0;
  logic soc_rst_i;
  always #5 wb_clk_i = ~wb_clk_i;

  logic [AW-1:0]    m_addr_i;
  logic [DW-1:0]    m_wdata_i;
  logic             m_we_i;
  logic [DW/8-1:0]  m_sel_i;
  logic             m_cyc_i;
  logic             m_stb_i;
  logic [DW-1:0]    m_rdata_o;
  logic             m_ack_o;
  logic [AW-1:0]    s_addr_o;
  logic [DW-1:0]    s_wdata_o;
  logic             s_we_o;
  logic [DW/8-1:0]  s_sel_o;
  logic [NS-1:0]    s_cyc_o;
  logic [NS-1:0]    s_stb_o;
  logic [NS*DW-1:0] s_rdata_i;
  logic [NS-1:0]    s_ack_i;
  logic             err_o;
  logic [AW-1:0]    err_addr_o;

  wb_xbar_1ton #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .N_SLAVES (NS),
    .SEL_LSB  (SL),
    .SEL_W    (SW),
    .TIMEOUT  (TO)
  ) dut (
    .wb_clk_i   (wb_clk_i),
    .soc_rst_i  (soc_rst_i),
    .m_addr_i   (m_addr_i),
    .m_wdata_i  (m_wdata_i),
    .m_we_i     (m_we_i),
    .m_sel_i    (m_sel_i),
    .m_cyc_i    (m_cyc_i),
    .m_stb_i    (m_stb_i),
    .m_rdata_o  (m_rdata_o),
    .m_ack_o    (m_ack_o),
    .s_addr_o   (s_addr_o),
    .s_wdata_o  (s_wdata_o),
    .s_we_o     (s_we_o),
    .s_sel_o    (s_sel_o),
    .s_cyc_o    (s_cyc_o),
    .s_stb_o    (s_stb_o),
    .s_rdata_i  (s_rdata_i),
    .s_ack_i    (s_ack_i),
    .err_o      (err_o),
    .err_addr_o (err_addr_o)
  );

  // ---------------- model state / scoreboard ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc_cnt = 0;
  int          ack_seen = -1;
  int          stb_cycles = 0;
  logic        ack_err_seen = 1'b0;
  logic        chk_en = 1'b0;

  logic [NS-1:0] exp_stb;
  logic          exp_we;
  logic          exp_ack;
  logic          exp_err;
  logic [DW-1:0] exp_rdata;
  logic [AW-1:0] exp_err_addr;

  always @(posedge wb_clk_i) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  // Compare process: every output, every cycle once reset has been applied.
  always @(negedge wb_clk_i) begin
    if (chk_en) begin
      chk("s_cyc_o",    64'(s_cyc_o),    64'(exp_stb));
      chk("s_stb_o",    64'(s_stb_o),    64'(exp_stb));
      chk("s_we_o",     64'(s_we_o),     64'(exp_we));
      chk("m_ack_o",    64'(m_ack_o),    64'(exp_ack));
      chk("err_o",      64'(err_o),      64'(exp_err));
      chk("m_rdata_o",  64'(m_rdata_o),  64'(exp_rdata));
      chk("err_addr_o", 64'(err_addr_o), 64'(exp_err_addr));
      chk("s_addr_o",   64'(s_addr_o),   64'(m_addr_i));
      chk("s_wdata_o",  64'(s_wdata_o),  64'(m_wdata_i));
      chk("s_sel_o",    64'(s_sel_o),    64'(m_sel_i));
      if (m_ack_o === 1'b1) begin
        ack_seen     = cyc_cnt;
        ack_err_seen = err_o;
      end
      if (|s_stb_o) stb_cycles++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic rand_rdata();
    for (int k = 0; k < NS; k++) s_rdata_i[k*DW +: DW] = $urandom();
  endtask

  // Quiet cycles with random stray acks that must be ignored.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      m_cyc_i = 1'b0; m_stb_i = 1'b0;
      m_addr_i = $urandom(); m_we_i = 1'($urandom_range(0, 1));
      s_ack_i = NS'($urandom_range(0, 15));
      rand_rdata();
      exp_stb = '0; exp_we = 1'b0; exp_ack = 1'b0; exp_err = 1'b0;
    end
  endtask

  // Response cycle, then the first idle cycle with the request dropped.
  task automatic resp(input logic e, input logic [DW-1:0] d, input logic [AW-1:0] a);
    s_ack_i = ($urandom_range(0, 3) == 0) ? NS'($urandom_range(0, 15)) : '0;
    rand_rdata();
    exp_stb = '0; exp_we = 1'b0; exp_ack = 1'b1; exp_err = e; exp_rdata = d;
    if (e) exp_err_addr = a;
    step();
    m_cyc_i = 1'b0; m_stb_i = 1'b0; s_ack_i = '0;
    exp_ack = 1'b0; exp_err = 1'b0;
  endtask

  // One master access. ack_dly: slave acks in its ack_dly-th strobed cycle
  // (0 = never). abort_at / rst_at: strobed cycle in which cyc is dropped or
  // reset is pulsed (0 = never). lat: 1-based cycle of m_ack_o counted from
  // the cycle the strobe is first presented, -1 if none.
  task automatic run_txn(input logic [AW-1:0] addr, input logic we, input logic [3:0] sel,
                         input logic [DW-1:0] wdata, input int ack_dly, input logic [DW-1:0] rd_force,
                         input int abort_at, input int rst_at, input int stray_at, input bit noisy,
                         output int lat);
    int            idx;
    int            start;
    logic [NS-1:0] oh;
    logic [DW-1:0] d;
    idx   = int'(addr[SL +: SW]);
    oh    = NS'(1 << idx);
    start = cyc_cnt;
    ack_seen = -1;
    stb_cycles = 0;
    m_addr_i = addr; m_we_i = we; m_sel_i = sel; m_wdata_i = wdata;
    m_cyc_i = 1'b1; m_stb_i = 1'b1; s_ack_i = '0;
    rand_rdata();
    exp_stb = '0; exp_we = 1'b0; exp_ack = 1'b0; exp_err = 1'b0;
    if (idx >= NS) begin
      step();
      resp(1'b1, 32'hDEAD_BEEF, addr);
    end else begin
      for (int k = 1; k <= TO; k++) begin
        step();
        rand_rdata();
        s_ack_i = noisy ? (NS'($urandom_range(0, 15)) & ~oh) : '0;
        if (k == stray_at) s_ack_i[(idx == 0) ? 1 : 0] = 1'b1;
        exp_stb = oh; exp_we = we;
        if (k == abort_at) begin
          m_cyc_i = 1'b0; m_stb_i = 1'b0; exp_stb = '0;
          step();
          s_ack_i = '0; exp_we = 1'b0;
          break;
        end
        if (k == rst_at) begin
          soc_rst_i = 1'b1;
          step();
          soc_rst_i = 1'b0; m_cyc_i = 1'b0; m_stb_i = 1'b0; s_ack_i = '0;
          exp_stb = '0; exp_we = 1'b0; exp_rdata = '0; exp_err_addr = '0;
          break;
        end
        if (k == ack_dly) begin
          if (rd_force != '0) s_rdata_i[idx*DW +: DW] = rd_force;
          s_ack_i[idx] = 1'b1;
          d = s_rdata_i[idx*DW +: DW];
          step();
          resp(1'b0, d, addr);
          break;
        end
        if (k == TO) begin
          step();
          resp(1'b1, 32'hDEAD_BEEF, addr);
        end
      end
    end
    lat = (ack_seen < 0) ? -1 : (ack_seen - start + 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    logic [AW-1:0] a;
    int dly, ab, rs, st;

    soc_rst_i = 1'b1;
    m_addr_i = '0; m_wdata_i = '0; m_we_i = 1'b0; m_sel_i = '0;
    m_cyc_i = 1'b0; m_stb_i = 1'b0; s_ack_i = '0; s_rdata_i = '0;
    exp_stb = '0; exp_we = 1'b0; exp_ack = 1'b0; exp_err = 1'b0;
    exp_rdata = '0; exp_err_addr = '0;
    step();
    chk_en = 1'b1;
    step();
    step();
    soc_rst_i = 1'b0;
    chk("reset m_ack_o", 64'(m_ack_o), 64'd0);
    chk("reset s_stb_o", 64'(s_stb_o), 64'd0);
    chk("reset m_rdata_o", 64'(m_rdata_o), 64'd0);

    // Read slave 2, ack in 3rd strobed cycle.
    run_txn(32'h0002_0010, 1'b0, 4'hF, 32'h0, 3, 32'h1234_5678, 0, 0, 0, 1'b0, lat);
    chk("t1 latency", 64'(lat), 64'(5));
    chk("t1 rdata", 64'(m_rdata_o), 64'h1234_5678);
    chk("t1 err", 64'(ack_err_seen), 64'd0);
    chk("t1 stb cycles", 64'(stb_cycles), 64'(3));
    idle(1);

    // Write slave 0, immediate ack.
    run_txn(32'h0000_0004, 1'b1, 4'b0011, 32'hA5A5_A5A5, 1, 32'h0, 0, 0, 0, 1'b0, lat);
    chk("t2 latency", 64'(lat), 64'(3));
    chk("t2 stb cycles", 64'(stb_cycles), 64'(1));
    idle(2);

    // Unmapped.
    run_txn(32'h0007_0000, 1'b0, 4'hF, 32'h0, 1, 32'h0, 0, 0, 0, 1'b0, lat);
    chk("t3 latency", 64'(lat), 64'(2));
    chk("t3 rdata", 64'(m_rdata_o), 64'hDEAD_BEEF);
    chk("t3 err", 64'(ack_err_seen), 64'd1);
    chk("t3 err_addr", 64'(err_addr_o), 64'h0007_0000);
    chk("t3 stb cycles", 64'(stb_cycles), 64'(0));

    // Slave 1 never acks -> timeout after 8 strobed cycles.
    run_txn(32'h0001_0020, 1'b0, 4'hF, 32'h0, 0, 32'h0, 0, 0, 0, 1'b0, lat);
    chk("t4 latency", 64'(lat), 64'(10));
    chk("t4 stb cycles", 64'(stb_cycles), 64'(8));
    chk("t4 rdata", 64'(m_rdata_o), 64'hDEAD_BEEF);
    chk("t4 err", 64'(ack_err_seen), 64'd1);
    chk("t4 err_addr", 64'(err_addr_o), 64'h0001_0020);
    idle(1);

    // Slave 3 acks on the expiry cycle, stray ack on slave 0 in cycle 3.
    run_txn(32'h0003_0000, 1'b0, 4'hF, 32'h0, 8, 32'hCAFE_F00D, 0, 0, 3, 1'b0, lat);
    chk("t5 latency", 64'(lat), 64'(10));
    chk("t5 err", 64'(ack_err_seen), 64'd0);
    chk("t5 rdata", 64'(m_rdata_o), 64'hCAFE_F00D);
    chk("t5 err_addr kept", 64'(err_addr_o), 64'h0001_0020);

    // Reset in ACTIVE.
    run_txn(32'h0002_0000, 1'b1, 4'hF, 32'h1, 5, 32'h0, 0, 3, 0, 1'b0, lat);
    chk("t6 no ack", 64'(lat), 64'(-1));
    chk("t6 rdata", 64'(m_rdata_o), 64'd0);
    chk("t6 err_addr", 64'(err_addr_o), 64'd0);
    idle(1);

    // Master abort in ACTIVE.
    run_txn(32'h0001_0000, 1'b0, 4'hF, 32'h0, 5, 32'h0, 2, 0, 0, 1'b0, lat);
    chk("t7 no ack", 64'(lat), 64'(-1));
    chk("t7 stb cycles", 64'(stb_cycles), 64'(1));

    // Next access after abort proceeds normally.
    run_txn(32'h0000_0008, 1'b0, 4'hF, 32'h0, 2, 32'h0BAD_CAFE, 0, 0, 0, 1'b0, lat);
    chk("t8 latency", 64'(lat), 64'(4));
    chk("t8 rdata", 64'(m_rdata_o), 64'h0BAD_CAFE);

    // Randomized accesses.
    for (int t = 0; t < 200; t++) begin
      a = $urandom();
      a[SL +: SW] = ($urandom_range(0, 9) < 7) ? 4'($urandom_range(0, NS - 1))
                                               : 4'($urandom_range(NS, 15));
      dly = $urandom_range(1, 11);
      ab  = ($urandom_range(0, 11) == 0) ? $urandom_range(1, TO) : 0;
      rs  = ($urandom_range(0, 19) == 0) ? $urandom_range(1, TO) : 0;
      st  = $urandom_range(0, 4);
      run_txn(a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom(),
              dly, 32'h0, ab, rs, st, 1'b1, lat);
      idle($urandom_range(0, 2));
    end

    idle(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule : tb_wb_xbar_1ton
